// File: rtl/div_axis_master.sv
// Sequencer between a pipeline EX-stage divide request and an AXI-Stream divider IP.
// It sends both operands, waits for the result and can discard a result after a flush.
module div_axis_master #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start,
    input  logic                  div_flush,
    input  logic [DATA_W-1:0]     div_dividend,
    input  logic [DATA_W-1:0]     div_divisor,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [DATA_W-1:0]     div_quotient,
    output logic [DATA_W-1:0]     div_remainder,
    output logic                  s_axis_dividend_tvalid,
    input  logic                  s_axis_dividend_tready,
    output logic [DATA_W-1:0]     s_axis_dividend_tdata,
    output logic                  s_axis_divisor_tvalid,
    input  logic                  s_axis_divisor_tready,
    output logic [DATA_W-1:0]     s_axis_divisor_tdata,
    input  logic                  m_axis_dout_tvalid,
    input  logic [2*DATA_W-1:0]   m_axis_dout_tdata,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

    state_t            state_q;
    logic              busy_q, done_q, flush_seen_q;
    logic              dvd_valid_q, dvs_valid_q;
    logic [DATA_W-1:0] dvd_data_q, dvs_data_q, quot_q, rem_q;
    logic              dvd_valid_d, dvs_valid_d, flush_seen_d;

    // A channel transfers on a cycle where tvalid & tready are both high; tvalid and
    // tdata stay stable until then. dout has no tready: any tvalid cycle is a transfer.
    always_comb begin
        dvd_valid_d  = dvd_valid_q & ~s_axis_dividend_tready;
        dvs_valid_d  = dvs_valid_q & ~s_axis_divisor_tready;
        flush_seen_d = flush_seen_q | div_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            flush_seen_q <= 1'b0;
            dvd_valid_q  <= 1'b0;
            dvs_valid_q  <= 1'b0;
            dvd_data_q   <= '0;
            dvs_data_q   <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_start && !div_flush) begin
                        if (div_divisor == '0) begin
                            // Divide-by-zero is answered locally, the IP is never involved.
                            done_q <= 1'b1;
                            quot_q <= '1;
                            rem_q  <= div_dividend;
                        end else begin
                            dvd_data_q   <= div_dividend;
                            dvs_data_q   <= div_divisor;
                            dvd_valid_q  <= 1'b1;
                            dvs_valid_q  <= 1'b1;
                            busy_q       <= 1'b1;
                            flush_seen_q <= 1'b0;
                            state_q      <= SEND;
                        end
                    end
                end
                SEND: begin
                    dvd_valid_q  <= dvd_valid_d;
                    dvs_valid_q  <= dvs_valid_d;
                    flush_seen_q <= flush_seen_d;
                    if (!dvd_valid_d && !dvs_valid_d) begin
                        state_q <= flush_seen_d ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (m_axis_dout_tvalid) begin
                        if (!div_flush) begin
                            quot_q <= m_axis_dout_tdata[2*DATA_W-1:DATA_W];
                            rem_q  <= m_axis_dout_tdata[DATA_W-1:0];
                            done_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (div_flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_axis_dout_tvalid) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_busy               = busy_q;
    assign div_done               = done_q;
    assign div_quotient           = quot_q;
    assign div_remainder          = rem_q;
    assign s_axis_dividend_tvalid = dvd_valid_q;
    assign s_axis_dividend_tdata  = dvd_data_q;
    assign s_axis_divisor_tvalid  = dvs_valid_q;
    assign s_axis_divisor_tdata   = dvs_data_q;
    assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_div_axis_master.sv
// Directed bench for div_axis_master with a small latency-N divider IP responder.
module tb_div_axis_master;

    localparam int W   = 32;
    localparam int LAT = 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2, S_DRAIN = 2'd3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           div_start = 1'b0, div_flush = 1'b0;
    logic [W-1:0]   div_dividend = '0, div_divisor = '0;
    logic           div_busy, div_done;
    logic [W-1:0]   div_quotient, div_remainder;
    logic           dvd_tvalid, dvs_tvalid;
    logic           dvd_tready = 1'b1, dvs_tready = 1'b1;
    logic [W-1:0]   dvd_tdata, dvs_tdata;
    logic           dout_tvalid = 1'b0;
    logic [2*W-1:0] dout_tdata = '0;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;

    // Cumulative monitor counts, sampled at negedge; main flow compares differences.
    int dvd_hi = 0, dvs_hi = 0, done_n = 0, busy_n = 0;

    div_axis_master #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .div_start(div_start), .div_flush(div_flush),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .s_axis_dividend_tvalid(dvd_tvalid), .s_axis_dividend_tready(dvd_tready),
        .s_axis_dividend_tdata(dvd_tdata),
        .s_axis_divisor_tvalid(dvs_tvalid), .s_axis_divisor_tready(dvs_tready),
        .s_axis_divisor_tdata(dvs_tdata),
        .m_axis_dout_tvalid(dout_tvalid), .m_axis_dout_tdata(dout_tdata),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Divider IP stand-in: captures operands on handshakes, answers LAT cycles later.
    initial begin
        logic [W-1:0] a, b;
        logic got_a, got_b;
        int cnt;
        got_a = 1'b0; got_b = 1'b0; cnt = 0; a = '0; b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_a = 1'b0; got_b = 1'b0; cnt = 0; dout_tvalid = 1'b0;
            end else begin
                dout_tvalid = 1'b0;
                if (dvd_tvalid && dvd_tready) begin a = dvd_tdata; got_a = 1'b1; end
                if (dvs_tvalid && dvs_tready) begin b = dvs_tdata; got_b = 1'b1; end
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        dout_tvalid = 1'b1;
                        dout_tdata  = {a / b, a % b};
                    end
                end
                if (got_a && got_b) begin
                    got_a = 1'b0; got_b = 1'b0; cnt = LAT;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                dvd_hi = dvd_hi + int'(dvd_tvalid);
                dvs_hi = dvs_hi + int'(dvs_tvalid);
                done_n = done_n + int'(div_done);
                busy_n = busy_n + int'(div_busy);
            end
        end
    end

    // checking task
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        div_dividend = a;
        div_divisor  = b;
        div_start    = 1'b1;
        tick();
        div_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (div_done) seen = 1'b1;
            else tick();
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        logic seen;
        int d0, v0, s0, b0;

        // reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst_busy", 64'(div_busy), 64'd0);
        chk("rst_done", 64'(div_done), 64'd0);
        chk("rst_tvalids", 64'({dvd_tvalid, dvs_tvalid}), 64'd0);
        chk("rst_tdata", 64'({dvd_tdata, dvs_tdata}), 64'd0);
        chk("rst_result", 64'({div_quotient, div_remainder}), 64'd0);

        // 142/12, both treadys high
        v0 = dvd_hi; s0 = dvs_hi; d0 = done_n;
        start_op(32'd142, 32'd12);
        chk("a_state_send", 64'(dbg_state), 64'(S_SEND));
        chk("a_busy", 64'(div_busy), 64'd1);
        chk("a_tvalids", 64'({dvd_tvalid, dvs_tvalid}), 64'b11);
        chk("a_tdata", 64'({dvd_tdata, dvs_tdata}), {32'd142, 32'd12});
        tick();
        chk("a_state_wait", 64'(dbg_state), 64'(S_WAIT));
        chk("a_tvalids_drop", 64'({dvd_tvalid, dvs_tvalid}), 64'b00);
        wait_done("a", seen);
        chk("a_quot", 64'(div_quotient), 64'd11);
        chk("a_rem", 64'(div_remainder), 64'd10);
        chk("a_busy_at_done", 64'(div_busy), 64'd0);
        tick();
        chk("a_done_one_cycle", 64'(div_done), 64'd0);
        chk("a_dvd_cycles", 64'(dvd_hi - v0), 64'd1);
        chk("a_dvs_cycles", 64'(dvs_hi - s0), 64'd1);
        chk("a_done_count", 64'(done_n - d0), 64'd1);

        // 100/7, divisor tready low for 3 cycles
        v0 = dvd_hi; s0 = dvs_hi;
        dvs_tready = 1'b0;
        start_op(32'd100, 32'd7);
        tick();
        chk("b_dvd_dropped", 64'(dvd_tvalid), 64'd0);
        chk("b_dvs_held", 64'({dvs_tvalid, dvs_tdata}), {31'd0, 1'b1, 32'd7});
        tick(); tick();
        chk("b_dvs_held2", 64'({dvs_tvalid, dvs_tdata}), {31'd0, 1'b1, 32'd7});
        chk("b_state_send", 64'(dbg_state), 64'(S_SEND));
        dvs_tready = 1'b1;
        wait_done("b", seen);
        chk("b_quot", 64'(div_quotient), 64'd14);
        chk("b_rem", 64'(div_remainder), 64'd2);
        chk("b_dvd_cycles", 64'(dvd_hi - v0), 64'd1);
        chk("b_dvs_cycles", 64'(dvs_hi - s0), 64'd4);

        // 100/0: answered locally
        tick();
        v0 = dvd_hi; s0 = dvs_hi; b0 = busy_n;
        start_op(32'd100, 32'd0);
        chk("z_done", 64'(div_done), 64'd1);
        chk("z_quot", 64'(div_quotient), 64'hFFFF_FFFF);
        chk("z_rem", 64'(div_remainder), 64'd100);
        chk("z_state", 64'(dbg_state), 64'(S_IDLE));
        tick(); tick(); tick();
        chk("z_no_tvalid", 64'((dvd_hi - v0) + (dvs_hi - s0)), 64'd0);
        chk("z_no_busy", 64'(busy_n - b0), 64'd0);

        // flush has priority over start in IDLE
        d0 = done_n;
        div_flush = 1'b1;
        start_op(32'd20, 32'd4);
        div_flush = 1'b0;
        chk("p_state", 64'(dbg_state), 64'(S_IDLE));
        chk("p_busy", 64'(div_busy), 64'd0);
        tick();
        chk("p_no_done", 64'(done_n - d0), 64'd0);

        // 50/3 flushed in WAIT, then 7/2
        d0 = done_n;
        start_op(32'd50, 32'd3);
        tick();
        chk("f_state_wait", 64'(dbg_state), 64'(S_WAIT));
        div_flush = 1'b1;
        tick();
        div_flush = 1'b0;
        chk("f_state_drain", 64'(dbg_state), 64'(S_DRAIN));
        for (int i = 0; i < 20 && dbg_state != S_IDLE; i++) tick();
        chk("f_back_idle", 64'(dbg_state), 64'(S_IDLE));
        tick();
        chk("f_no_done", 64'(done_n - d0), 64'd0);
        chk("f_result_kept", 64'({div_quotient, div_remainder}), {32'hFFFF_FFFF, 32'd100});
        start_op(32'd7, 32'd2);
        wait_done("f2", seen);
        chk("f2_quot", 64'(div_quotient), 64'd3);
        chk("f2_rem", 64'(div_remainder), 64'd1);
        tick();

        // reset mid-SEND, then 9/4
        dvs_tready = 1'b0;
        start_op(32'd200, 32'd5);
        tick();
        chk("r_state_send", 64'(dbg_state), 64'(S_SEND));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dvs_tready = 1'b1;
        chk("r_state", 64'(dbg_state), 64'(S_IDLE));
        chk("r_outputs", 64'({div_busy, div_done, dvd_tvalid, dvs_tvalid}), 64'd0);
        chk("r_tdata", 64'({dvd_tdata, dvs_tdata}), 64'd0);
        chk("r_result", 64'({div_quotient, div_remainder}), 64'd0);
        tick();
        start_op(32'd9, 32'd4);
        wait_done("r2", seen);
        chk("r2_quot", 64'(div_quotient), 64'd2);
        chk("r2_rem", 64'(div_remainder), 64'd1);
        tick();

        // start repeated while busy is ignored; back-to-back start at done
        d0 = done_n;
        start_op(32'd142, 32'd12);
        tick();
        start_op(32'd50, 32'd3);
        start_op(32'd60, 32'd7);
        wait_done("g", seen);
        chk("g_quot", 64'(div_quotient), 64'd11);
        chk("g_rem", 64'(div_remainder), 64'd10);
        start_op(32'd9, 32'd2);
        chk("g_b2b_state", 64'(dbg_state), 64'(S_SEND));
        wait_done("g2", seen);
        chk("g2_quot", 64'(div_quotient), 64'd4);
        chk("g2_rem", 64'(div_remainder), 64'd1);
        tick(); tick(); tick();
        chk("g_done_count", 64'(done_n - d0), 64'd2);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_axis_master.md
DIV_AXIS_MASTER -- requirements
Module: div_axis_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width (matches `DATA_BUS).
REQ-002 SHALL have port clk  in  1  single clock for all logic.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port div_start  in  1  one-cycle request from EX stage.
REQ-005 SHALL have port div_flush  in  1  pipeline flush; cancels the in-flight operation.
REQ-006 SHALL have port div_dividend  in  DATA_W  dividend, sampled with div_start.
REQ-007 SHALL have port div_divisor  in  DATA_W  divisor, sampled with div_start.
REQ-008 SHALL have port div_busy  out  1  operation in flight; EX stage stalls on it.
REQ-009 SHALL have port div_done  out  1  one-cycle result-valid pulse.
REQ-010 SHALL have ports div_quotient and div_remainder  out  DATA_W each  registered result.
REQ-011 SHALL have ports s_axis_dividend_tvalid out 1, s_axis_dividend_tready in 1, s_axis_dividend_tdata out DATA_W.
REQ-012 SHALL have ports s_axis_divisor_tvalid out 1, s_axis_divisor_tready in 1, s_axis_divisor_tdata out DATA_W.
REQ-013 SHALL have ports m_axis_dout_tvalid in 1 and m_axis_dout_tdata in 2*DATA_W; [2*DATA_W-1:DATA_W] is the quotient and [DATA_W-1:0] the remainder.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND, WAIT and DRAIN, with div_busy registered and high in every state except IDLE.
REQ-015 SHALL, in IDLE on div_start with div_divisor != 0 and no flush, latch both operands onto the tdata outputs, raise both tvalids on the next cycle, and go to SEND.
REQ-016 SHALL, in SEND, hold each channel's tvalid and tdata stable until that channel's tvalid&tready handshake, then drop that channel's tvalid on the next cycle; the two channels complete independently.
REQ-017 SHALL leave SEND for WAIT once both channels have handshaken, including the case where both handshake in the same cycle.
REQ-018 SHALL, in WAIT on m_axis_dout_tvalid, load quotient/remainder from dout_tdata, pulse div_done for exactly one cycle (the next cycle), drop div_busy in that same cycle, and return to IDLE.
REQ-019 SHALL treat m_axis_dout_tvalid as always accepted (no tready); outside WAIT/DRAIN it is ignored.
REQ-020 SHALL handle divide-by-zero in IDLE (start with div_divisor == 0) without any AXI transaction: next cycle div_done=1, quotient=all-ones, remainder=dividend, state stays IDLE.
REQ-021 SHALL ignore div_start while div_busy=1 (no second operation queued).
REQ-022 SHALL, on div_flush in SEND, keep the pending tvalids asserted until their handshakes complete (no AXI valid retraction), then go to DRAIN instead of WAIT.
REQ-023 SHALL, on div_flush in WAIT, go to DRAIN; if dout_tvalid arrives in the same cycle, discard it and go to IDLE.
REQ-024 SHALL, in DRAIN, discard the next dout_tvalid without asserting div_done or updating results, then go to IDLE.
REQ-025 SHALL give div_flush priority over div_start in the same IDLE cycle: no operation starts and no done pulse is produced.
REQ-026 SHALL accept div_start in the cycle div_done is high (back-to-back operation).
REQ-027 SHALL hold div_quotient/div_remainder until the next completed (non-flushed) operation.

Reset
REQ-028 SHALL, with rst=1 at a clk edge, force state IDLE, all tvalids 0, div_busy 0, div_done 0, and tdata, quotient and remainder to 0, regardless of the current state.
REQ-029 SHALL require the divider IP's reset to be driven from the same rst, so retracting tvalid on reset mid-SEND is legal.

Verification
REQ-030 SHALL test: 142/12 with both treadys high, IP latency N -> both tvalids high for 1 cycle, div_done 1 cycle after dout_tvalid, quotient=11, remainder=10.
REQ-031 SHALL test: 100/7 with divisor_tready low for 3 cycles -> dividend_tvalid drops after 1 cycle, divisor_tvalid/tdata=7 held 4 cycles, then quotient=14, remainder=2.
REQ-032 SHALL test: 100/0 -> no tvalid ever asserted, div_done the next cycle, quotient=0xFFFFFFFF, remainder=100, div_busy stays 0.
REQ-033 SHALL test: div_flush during WAIT of 50/3, then dout arrives -> no div_done, results unchanged; a following 7/2 gives quotient=3, remainder=1.
REQ-034 SHALL test: rst during SEND -> next cycle all outputs 0 and state IDLE; a new 9/4 gives quotient=2, remainder=1.
REQ-035 SHALL test: div_start pulsed again while busy with 142/12 -> ignored, exactly one div_done, quotient=11.
